// File: rtl/pdm_receiver.sv
// PDM microphone receiver: edge-detects pdm_clk_i, synchronises pdm_data_i and
// decimates by ones-counting into a 1-deep valid/ready output buffer.
// Optional macro PDM_RX_OVF_CNT_EN adds an 8-bit saturating dropped-word counter.
module pdm_receiver #(
    parameter int unsigned DECIM       = 128,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned CNT_W      = $clog2(DECIM + 1)
) (
    input  logic             og_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pdm_clk_i,
    input  logic             pdm_data_i,
    output logic [CNT_W-1:0] pcm_data,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic             overflow
`ifdef PDM_RX_OVF_CNT_EN
    ,
    output logic [7:0]       ovf_count
`endif
);

    localparam int unsigned LAST = DECIM - 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    state_e                 state_q;
    logic                   clk_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       acc_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   rise_c;
    logic                   pdm_bit_c;
    logic                   active_c;
    logic                   done_c;
    logic                   en_fall_c;
    logic                   drop_c;
    logic [CNT_W-1:0]       word_c;

    assign rise_c    = pdm_clk_i & ~clk_q;
    assign pdm_bit_c = sync_q[SYNC_STAGES-1];
    assign active_c  = (state_q == ACCUM) && en;
    assign done_c    = active_c && rise_c && (cnt_q == CNT_W'(LAST));
    // state_q lags en by one cycle, so ACCUM with en low marks the 1->0 edge
    assign en_fall_c = (state_q == ACCUM) && !en;
    assign drop_c    = done_c && pcm_valid && !pcm_ready;
    assign word_c    = acc_q + CNT_W'(pdm_bit_c);

    // pdm clock edge register and data synchroniser
    always_ff @(posedge og_clk or negedge rst) begin
        if (!rst) begin
            clk_q  <= 1'b0;
            sync_q <= '0;
        end else begin
            clk_q  <= pdm_clk_i;
            sync_q <= {sync_q[SYNC_STAGES-2:0], pdm_data_i};
        end
    end

    // capture FSM and boxcar accumulator
    always_ff @(posedge og_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (en) begin
                        state_q <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!en) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end else if (rise_c) begin
                        if (done_c) begin
                            acc_q <= '0;
                            cnt_q <= '0;
                        end else begin
                            acc_q <= word_c;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // 1-deep output buffer; a completed word may replace one being accepted
    always_ff @(posedge og_clk or negedge rst) begin
        if (!rst) begin
            pcm_data  <= '0;
            pcm_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (done_c && (!pcm_valid || pcm_ready)) begin
                pcm_data  <= word_c;
                pcm_valid <= 1'b1;
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end

            if (en_fall_c) begin
                overflow <= 1'b0;
            end else if (drop_c) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef PDM_RX_OVF_CNT_EN
    // saturating count of dropped words, cleared like overflow
    always_ff @(posedge og_clk or negedge rst) begin
        if (!rst) begin
            ovf_count <= 8'd0;
        end else if (en_fall_c) begin
            ovf_count <= 8'd0;
        end else if (drop_c && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pdm_receiver.sv
// Directed bench for pdm_receiver (DECIM=128) with a fast pdm_clk_i (10 og_clk period).
// Define PDM_RX_OVF_CNT_EN for both files to also check ovf_count.
module tb_pdm_receiver;

    localparam int unsigned DECIM = 128;
    localparam int unsigned HALF  = 5;

    logic       og_clk;
    logic       rst;
    logic       en;
    logic       pdm_clk_i;
    logic       pdm_data_i;
    logic [7:0] pcm_data;
    logic       pcm_valid;
    logic       pcm_ready;
    logic       overflow;
`ifdef PDM_RX_OVF_CNT_EN
    logic [7:0] ovf_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pdm_receiver #(
        .DECIM       (DECIM),
        .SYNC_STAGES (2)
    ) dut (
        .og_clk     (og_clk),
        .rst        (rst),
        .en         (en),
        .pdm_clk_i  (pdm_clk_i),
        .pdm_data_i (pdm_data_i),
        .pcm_data   (pcm_data),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .overflow   (overflow)
`ifdef PDM_RX_OVF_CNT_EN
        ,
        .ovf_count  (ovf_count)
`endif
    );

    initial og_clk = 1'b0;
    always #5 og_clk = ~og_clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // mode 0: all zeros, 1: all ones, 2: alternating starting with 1
    function automatic logic pat_bit(input int mode, input int i);
        if (mode == 2) return (i % 2) == 0;
        return mode != 0;
    endfunction

    // one pdm period; v is pcm_valid one cycle after the rise is seen
    task automatic pdm_sample(input logic b, output logic v);
        pdm_clk_i  = 1'b0;
        pdm_data_i = b;
        repeat (HALF) @(negedge og_clk);
        pdm_clk_i = 1'b1;
        @(negedge og_clk);
        v = pcm_valid;
        repeat (HALF - 1) @(negedge og_clk);
    endtask

    task automatic run_samples(input int mode, input int n, output logic early);
        logic v;
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            pdm_sample(pat_bit(mode, i), v);
            early = early | v;
        end
    endtask

    // last sample of a frame; returns one cycle after the completing rise
    task automatic final_sample(input int mode, input logic ready_at_edge);
        pdm_clk_i  = 1'b0;
        pdm_data_i = pat_bit(mode, DECIM - 1);
        repeat (HALF) @(negedge og_clk);
        if (ready_at_edge) pcm_ready = 1'b1;
        pdm_clk_i = 1'b1;
        @(negedge og_clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic early;
        rst        = 1'b0;
        en         = 1'b0;
        pdm_clk_i  = 1'b0;
        pdm_data_i = 1'b0;
        pcm_ready  = 1'b0;
        repeat (3) @(negedge og_clk);
        check("rst_data", 32'(pcm_data), 0);
        check("rst_valid", 32'(pcm_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
`ifdef PDM_RX_OVF_CNT_EN
        check("rst_ovfcnt", 32'(ovf_count), 0);
`endif
        rst = 1'b1;
        @(negedge og_clk);

        // all ones, always ready
        en        = 1'b1;
        pcm_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            run_samples(1, DECIM - 1, early);
            check("t1_early", 32'(early), 0);
            final_sample(1, 1'b0);
            check("t1_data", 32'(pcm_data), 128);
            check("t1_valid", 32'(pcm_valid), 1);
            check("t1_ovf", 32'(overflow), 0);
            @(negedge og_clk);
            check("t1_pulse", 32'(pcm_valid), 0);
            repeat (HALF) @(negedge og_clk);
        end

        // alternating then all-zero frames
        run_samples(2, DECIM - 1, early);
        check("t2_early", 32'(early), 0);
        final_sample(2, 1'b0);
        check("t2_alt", 32'(pcm_data), 64);
        check("t2_valid", 32'(pcm_valid), 1);
        repeat (HALF) @(negedge og_clk);
        run_samples(0, DECIM - 1, early);
        final_sample(0, 1'b0);
        check("t2_zero", 32'(pcm_data), 0);
        check("t2_zvalid", 32'(pcm_valid), 1);
        repeat (HALF) @(negedge og_clk);

        // ready exactly in the completion cycle of the next word
        pcm_ready = 1'b0;
        run_samples(1, DECIM - 1, early);
        final_sample(1, 1'b0);
        check("t4_first", 32'(pcm_data), 128);
        repeat (HALF) @(negedge og_clk);
        run_samples(2, DECIM - 1, early);
        check("t4_held", 32'(pcm_data), 128);
        check("t4_hvalid", 32'(pcm_valid), 1);
        final_sample(2, 1'b1);
        pcm_ready = 1'b0;
        check("t4_data", 32'(pcm_data), 64);
        check("t4_valid", 32'(pcm_valid), 1);
        check("t4_ovf", 32'(overflow), 0);
        pcm_ready = 1'b1;
        @(negedge og_clk);
        pcm_ready = 1'b0;
        check("t4_acc", 32'(pcm_valid), 0);
        repeat (HALF) @(negedge og_clk);

        // two frames without ready: second word dropped
        run_samples(1, DECIM - 1, early);
        final_sample(1, 1'b0);
        check("t3_w1", 32'(pcm_data), 128);
        check("t3_ovf0", 32'(overflow), 0);
        repeat (HALF) @(negedge og_clk);
        run_samples(0, DECIM - 1, early);
        final_sample(0, 1'b0);
        check("t3_ovf1", 32'(overflow), 1);
        check("t3_keep", 32'(pcm_data), 128);
        check("t3_valid", 32'(pcm_valid), 1);
`ifdef PDM_RX_OVF_CNT_EN
        check("t3_ovfcnt", 32'(ovf_count), 1);
`endif
        pcm_ready = 1'b1;
        @(negedge og_clk);
        pcm_ready = 1'b0;
        check("t3_acc", 32'(pcm_valid), 0);
        check("t3_data", 32'(pcm_data), 128);
        check("t3_sticky", 32'(overflow), 1);
        repeat (HALF) @(negedge og_clk);

        // reset mid-frame at sample 50
        pcm_ready = 1'b1;
        run_samples(1, 50, early);
        pdm_clk_i = 1'b0;
        @(negedge og_clk);
        rst = 1'b0;
        #1;
        check("t5_data", 32'(pcm_data), 0);
        check("t5_valid", 32'(pcm_valid), 0);
        check("t5_ovf", 32'(overflow), 0);
`ifdef PDM_RX_OVF_CNT_EN
        check("t5_ovfcnt", 32'(ovf_count), 0);
`endif
        @(negedge og_clk);
        rst = 1'b1;
        run_samples(1, DECIM - 1, early);
        check("t5_early", 32'(early), 0);
        final_sample(1, 1'b0);
        check("t5_word", 32'(pcm_data), 128);
        check("t5_wvalid", 32'(pcm_valid), 1);
        repeat (HALF) @(negedge og_clk);

        // en drop at sample 70: partial discarded, overflow cleared, word kept
        pcm_ready = 1'b0;
        run_samples(1, DECIM - 1, early);
        final_sample(1, 1'b0);
        repeat (HALF) @(negedge og_clk);
        run_samples(1, DECIM - 1, early);
        final_sample(1, 1'b0);
        check("t6_ovf1", 32'(overflow), 1);
`ifdef PDM_RX_OVF_CNT_EN
        check("t6_ovfcnt1", 32'(ovf_count), 1);
`endif
        repeat (HALF) @(negedge og_clk);
        run_samples(1, 70, early);
        pdm_clk_i = 1'b0;
        en        = 1'b0;
        repeat (3) @(negedge og_clk);
        check("t6_ovfclr", 32'(overflow), 0);
        check("t6_kvalid", 32'(pcm_valid), 1);
        check("t6_kdata", 32'(pcm_data), 128);
`ifdef PDM_RX_OVF_CNT_EN
        check("t6_ovfcnt0", 32'(ovf_count), 0);
`endif
        en        = 1'b1;
        pcm_ready = 1'b1;
        @(negedge og_clk);
        check("t6_acc", 32'(pcm_valid), 0);
        run_samples(2, DECIM - 1, early);
        check("t6_early", 32'(early), 0);
        final_sample(2, 1'b0);
        check("t6_word", 32'(pcm_data), 64);
        check("t6_wvalid", 32'(pcm_valid), 1);
        repeat (HALF) @(negedge og_clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
